uart_rx_word_packer: RTL

- Receive-side counterpart of the fixed-buffer UART transmit path: deserialises 8N1 UART frames from the Rx pin.
- Packs consecutive bytes into a 64-bit word, first received byte in bits [7:0], matching the transmitter's LSB-byte-first buffer shifting.
- Sits between the Rx pad and user logic; runs directly on the system clock, with no divided clock.

---
 rtl/uart_pkg.sv | 14 +
 rtl/uart_rx_word_packer_if.sv | 24 ++
 rtl/uart_rx_core.sv | 123 ++++++++++++
 rtl/uart_rx_word_packer.sv | 95 +++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART receive definitions: FSM states, default bit timing and frame width.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int DEFAULT_CLKS_PER_BIT = 5208;
  localparam int UART_DATA_BITS       = 8;

endpackage

// File: rtl/uart_rx_word_packer_if.sv
// Serial input, flush request and byte/word result bundle of the UART receive word packer.
interface uart_rx_word_packer_if;

  logic        Rx;
  logic        flush;
  logic [7:0]  byte_data;
  logic        byte_valid;
  logic [63:0] word_data;
  logic        word_valid;
  logic [3:0]  byte_count;
  logic        frame_err;
  logic        busy;

  modport master (
    output Rx, flush,
    input  byte_data, byte_valid, word_data, word_valid, byte_count, frame_err, busy
  );

  modport slave (
    input  Rx, flush,
    output byte_data, byte_valid, word_data, word_valid, byte_count, frame_err, busy
  );

endinterface

// File: rtl/uart_rx_core.sv
// 8N1 receiver: Rx synchroniser, start/data/stop FSM, registered byte output and frame error.
// store_stb_o/store_data_o flag a good stop bit one cycle before byte_valid_o so the packer can align its word pulse.
module uart_rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rx_i,
  output logic [UART_DATA_BITS-1:0] byte_data_o,
  output logic                      byte_valid_o,
  output logic                      frame_err_o,
  output logic                      busy_o,
  output logic                      store_stb_o,
  output logic [UART_DATA_BITS-1:0] store_data_o
);

  localparam int              CNT_W    = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);

  logic [1:0]                sync_q;
  logic                      rx_s;
  uart_state_e               state_q, state_d;
  logic [CNT_W-1:0]          clk_cnt_q, clk_cnt_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [UART_DATA_BITS-1:0] byte_data_q, byte_data_d;
  logic                      byte_valid_q, byte_valid_d;
  logic                      frame_err_q, frame_err_d;
  logic                      brk_q, brk_d;
  logic                      store_stb;

  assign rx_s = sync_q[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q       <= 2'b11;
      state_q      <= IDLE;
      clk_cnt_q    <= '0;
      bit_idx_q    <= '0;
      shift_q      <= '0;
      byte_data_q  <= '0;
      byte_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      brk_q        <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], rx_i};
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_idx_q    <= bit_idx_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_valid_q <= byte_valid_d;
      frame_err_q  <= frame_err_d;
      brk_q        <= brk_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q + CNT_W'(1);
    bit_idx_d    = bit_idx_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_valid_d = 1'b0;
    frame_err_d  = 1'b0;
    brk_d        = brk_q;
    store_stb    = 1'b0;
    unique case (state_q)
      IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        if (clk_cnt_q == CNT_HALF) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        // A low stop bit is treated as a break: hold here until the line returns high.
        if (brk_q) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            brk_d   = 1'b0;
            state_d = IDLE;
          end
        end else if (clk_cnt_q == CNT_FULL) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            byte_data_d  = shift_q;
            byte_valid_d = 1'b1;
            store_stb    = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            brk_d       = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign byte_data_o  = byte_data_q;
  assign byte_valid_o = byte_valid_q;
  assign frame_err_o  = frame_err_q;
  assign busy_o       = (state_q != IDLE);
  assign store_stb_o  = store_stb;
  assign store_data_o = shift_q;

endmodule

// File: rtl/uart_rx_word_packer.sv
// UART receiver that packs received bytes LSB-lane-first into a 64-bit word, with flush of partial words.
module uart_rx_word_packer
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int WORD_BYTES   = 8
) (
  input logic                  clk,
  input logic                  rxrst,
  uart_rx_word_packer_if.slave bus
);

  localparam logic [3:0] LAST_LANE = 4'(WORD_BYTES - 1);

  logic [UART_DATA_BITS-1:0] core_byte;
  logic                      core_valid;
  logic                      core_ferr;
  logic                      core_busy;
  logic                      store_stb;
  logic [UART_DATA_BITS-1:0] store_data;

  logic [63:0] buf_q, buf_d;
  logic [63:0] filled;
  logic [3:0]  count_q, count_d;
  logic [63:0] word_q, word_d;
  logic        word_valid_q, word_valid_d;
  logic        flush_pend_q, flush_pend_d;

  uart_rx_core #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_core (
    .clk         (clk),
    .rst         (rxrst),
    .rx_i        (bus.Rx),
    .byte_data_o (core_byte),
    .byte_valid_o(core_valid),
    .frame_err_o (core_ferr),
    .busy_o      (core_busy),
    .store_stb_o (store_stb),
    .store_data_o(store_data)
  );

  always_ff @(posedge clk or posedge rxrst) begin
    if (rxrst) begin
      buf_q        <= '0;
      count_q      <= '0;
      word_q       <= '0;
      word_valid_q <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      buf_q        <= buf_d;
      count_q      <= count_d;
      word_q       <= word_d;
      word_valid_q <= word_valid_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  // A flush that collides with a byte store is parked in flush_pend_q and applied next cycle.
  always_comb begin
    buf_d        = buf_q;
    count_d      = count_q;
    word_d       = word_q;
    word_valid_d = 1'b0;
    flush_pend_d = 1'b0;
    filled       = buf_q;
    filled[{count_q[2:0], 3'b000} +: 8] = store_data;
    if (store_stb) begin
      if (count_q == LAST_LANE) begin
        word_d       = filled;
        word_valid_d = 1'b1;
        buf_d        = '0;
        count_d      = '0;
      end else begin
        buf_d        = filled;
        count_d      = count_q + 4'd1;
        flush_pend_d = flush_pend_q | bus.flush;
      end
    end else if ((bus.flush || flush_pend_q) && (count_q != 4'd0)) begin
      word_d       = buf_q;
      word_valid_d = 1'b1;
      buf_d        = '0;
      count_d      = '0;
    end
  end

  assign bus.byte_data  = core_byte;
  assign bus.byte_valid = core_valid;
  assign bus.frame_err  = core_ferr;
  assign bus.busy       = core_busy;
  assign bus.word_data  = word_q;
  assign bus.word_valid = word_valid_q;
  assign bus.byte_count = count_q;

endmodule
